// File: rtl/rs_encoder_18_16.sv
`default_nettype none
// ============================================================================
//  Module      : rs_encoder_18_16
//  Description : Systematic Reed-Solomon RS(18,16) encoder over GF(2^5).
//                Data symbols are forwarded unchanged. Two parity symbols
//                from a 2-stage LFSR with g(x) = x^2 + G1*x + G0 are then
//                appended. Input and output use valid/ready streams.
//                Optional build macro RS_ENC_FRAME_CHECK_EN adds in_last and
//                a sticky frame_err flag for framing checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_encoder_18_16 #(
    parameter int               SYM_W     = 5,
    parameter int               N         = 18,
    parameter int               K         = 16,
    parameter logic [SYM_W-1:0] PRIM_POLY = 5'b00101,
    parameter logic [SYM_W-1:0] G1        = 5'd6,
    parameter logic [SYM_W-1:0] G0        = 5'd8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_data,
    output logic             out_last,
    output logic             out_parity
`ifdef RS_ENC_FRAME_CHECK_EN
    ,
    input  logic             in_last,
    output logic             frame_err
`endif
);

    // Symbol counter width and terminal values
    localparam int             CW         = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0]  c_sym_last = CW'(K - 1);
    localparam logic [CW-1:0]  c_cnt_one  = CW'(1);
    localparam logic [0:0]     c_par_last = 1'(N - K - 1);

    typedef enum logic [0:0] {
        ST_DATA = 1'b0,
        ST_PAR  = 1'b1
    } state_t;

    // GF(2^SYM_W) multiply by shift-and-reduce (Horner over the bits of b).
    // Called with constant b, so it collapses to a small XOR network.
    function automatic logic [SYM_W-1:0] gf_mul(
        input logic [SYM_W-1:0] a,
        input logic [SYM_W-1:0] b
    );
        logic [SYM_W-1:0] p;
        p = '0;
        for (int i = SYM_W - 1; i >= 0; i--) begin
            p = {p[SYM_W-2:0], 1'b0} ^ (p[SYM_W-1] ? PRIM_POLY : '0);
            if (b[i]) begin
                p = p ^ a;
            end
        end
        return p;
    endfunction

    state_t            r_state;
    logic [CW-1:0]     r_sym_cnt;
    logic [0:0]        r_par_cnt;
    logic [SYM_W-1:0]  r_r1;
    logic [SYM_W-1:0]  r_r0;
    logic              r_out_valid;
    logic [SYM_W-1:0]  r_out_data;
    logic              r_out_last;
    logic              r_out_parity;

    logic              w_slot_free;
    logic              w_in_fire;
    logic [SYM_W-1:0]  w_fb;
    logic [SYM_W-1:0]  w_fb_g1;
    logic [SYM_W-1:0]  w_fb_g0;

    // The output register can take a new symbol when empty or being drained
    assign w_slot_free = !r_out_valid || out_ready;
    // Input is only accepted in DATA with a free output slot; held off in reset
    assign in_ready    = reset_n && (r_state == ST_DATA) && w_slot_free;
    assign w_in_fire   = in_valid && in_ready;

    // LFSR feedback: incoming symbol plus the high-order remainder stage
    assign w_fb    = in_data ^ r_r1;
    assign w_fb_g1 = gf_mul(w_fb, G1);
    assign w_fb_g0 = gf_mul(w_fb, G0);

`ifdef RS_ENC_FRAME_CHECK_EN
    logic r_frame_err;
    logic w_frame_bad;

    // A symbol is misframed when in_last disagrees with the counter position
    assign w_frame_bad = w_in_fire && (in_last != (r_sym_cnt == c_sym_last));
    assign frame_err   = r_frame_err;

    // Sticky framing error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_frame_err <= 1'b0;
        end else if (w_frame_bad) begin
            r_frame_err <= 1'b1;
        end
    end
`endif

    // Encoder FSM with LFSR and registered output stage
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_DATA;
            r_sym_cnt    <= '0;
            r_par_cnt    <= '0;
            r_r1         <= '0;
            r_r0         <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_out_parity <= 1'b0;
        end else begin
            // A taken symbol empties the slot unless something reloads it below
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_DATA: begin
                    if (w_in_fire) begin
                        r_r1         <= r_r0 ^ w_fb_g1;
                        r_r0         <= w_fb_g0;
                        r_out_valid  <= 1'b1;
                        r_out_data   <= in_data;
                        r_out_parity <= 1'b0;
                        r_out_last   <= 1'b0;
                        if (r_sym_cnt == c_sym_last) begin
                            r_sym_cnt <= '0;
                            r_state   <= ST_PAR;
                        end else begin
                            r_sym_cnt <= r_sym_cnt + c_cnt_one;
                        end
                    end
                end

                ST_PAR: begin
                    if (w_slot_free) begin
                        r_out_valid  <= 1'b1;
                        r_out_parity <= 1'b1;
                        if (r_par_cnt != c_par_last) begin
                            // High-order parity first
                            r_out_data <= r_r1;
                            r_out_last <= 1'b0;
                            r_par_cnt  <= r_par_cnt + 1'b1;
                        end else begin
                            // Final parity closes the codeword; LFSR restarts
                            r_out_data <= r_r0;
                            r_out_last <= 1'b1;
                            r_par_cnt  <= '0;
                            r_r1       <= '0;
                            r_r0       <= '0;
                            r_state    <= ST_DATA;
                        end
                    end
                end

                default: begin
                    r_state <= ST_DATA;
                end
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign out_parity = r_out_parity;

endmodule
`default_nettype wire

// File: doc/rs_encoder_18_16.md
Name: rs_encoder_18_16

Overview:
- Systematic Reed-Solomon RS(18,16) encoder over GF(2^5).
- Accepts a frame of 16 data symbols on a valid/ready stream and forwards them unchanged.
- Appends 2 parity symbols computed by a 2-stage LFSR with generator g(x) = (x+α)(x+α^2) = x^2 + 6x + 8.
- Sits at the transmit side and produces the codewords that the decoder-side GF arithmetic consumes.

Parameters:
- SYM_W, 5, symbol width in bits.
- N, 18, codeword length in symbols.
- K, 16, data symbols per codeword. N-K is fixed at 2.
- PRIM_POLY, 5'b00101, low bits of the field primitive polynomial x^5+x^2+1.
- G1, 6, generator coefficient of x^1.
- G0, 8, generator coefficient of x^0.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  encoder can accept an input symbol.
- in_data  in  SYM_W  data symbol; the first symbol is the highest-degree coefficient.
- out_valid  out  1  output symbol valid.
- out_ready  in  1  downstream accepts the output symbol.
- out_data  out  SYM_W  codeword symbol.
- out_last  out  1  high on the final (18th) symbol of a codeword.
- out_parity  out  1  high while out_data is a parity symbol.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low; clock port is clk, reset port is reset_n.
- GF multiply: constant multipliers by G1 and G0, built as shift-and-reduce modulo PRIM_POLY. Purely combinational, no lookup tables.
- GF add: XOR.
- State machine, two states:
  - DATA: sym_cnt runs 0..K-1.
  - PAR: par_cnt runs 0..1.
- Input accept: in_ready = (state==DATA) && (!out_valid || out_ready). A transfer occurs on in_valid && in_ready.
- On each input accept:
  - f = in_data ^ r1; r1 <= r0 ^ G1·f; r0 <= G0·f.
  - out_data <= in_data; out_valid <= 1; out_parity <= 0; out_last <= 0.
  - sym_cnt increments. When sym_cnt==K-1, state goes to PAR and sym_cnt goes to 0.
- PAR, when !out_valid || out_ready (output slot free):
  - Emit r1 (par_cnt 0), then r0 (par_cnt 1). out_parity = 1.
  - out_last = 1 on the r0 symbol.
  - After r0 is loaded into the output register: r1, r0 clear to 0 and state returns to DATA.
- Output register: holds its value while out_valid && !out_ready. out_valid clears when the symbol is taken and nothing new is loaded.
- Latency: 1 cycle from input accept to out_valid. The first parity symbol is available the cycle after the 16th data symbol leaves the output register, or earlier if the output slot is free.
- Throughput: 18 output symbols per 16 input symbols. in_ready is low for exactly 2 output transfers per codeword.
- Reset (reset_n==0 at a clock edge):
  - out_valid=0, out_data=0, out_last=0, out_parity=0.
  - r1=r0=0, state=DATA, counters=0.
  - in_ready is low during reset.
  - Reset mid-frame discards the partial codeword. The next accepted symbol is data symbol 0.
- Back-to-back codewords: a new frame's symbol 0 may be accepted in the cycle the r0 parity symbol is taken.

Optional Feature:
- Macro RS_ENC_FRAME_CHECK_EN.
- When defined:
  - Adds input port in_last (1 bit) and output port frame_err (1 bit, reset 0, sticky until reset).
  - frame_err sets on an accepted symbol where in_last != (sym_cnt==K-1).
  - Encoding proceeds by sym_cnt regardless of in_last.
- When undefined:
  - Neither port exists.
  - Framing is determined only by sym_cnt.

Test Plan:
- Reset, then 16 zero symbols with out_ready=1 -> 18 outputs all 0; out_parity high on outputs 17-18; out_last high on output 18 only.
- 15 zeros then 1 -> data echoed; parity r1=6, r0=8.
- 14 zeros, then 1, then 0 -> parity r1=28, r0=21.
- Frame from the previous scenario with out_ready toggled randomly -> identical 18-symbol sequence with no drop or duplicate; out_data stable while stalled; in_ready=0 during both parity outputs.
- Assert reset_n=0 for one cycle after 7 symbols, then send the 15-zeros+1 frame -> parity 6, 8; all outputs 0 the cycle after reset.
- With RS_ENC_FRAME_CHECK_EN: assert in_last on symbol 10 -> frame_err=1 from the next cycle and remains 1; the codeword is still emitted per sym_cnt.
